// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding, mux-select constants and counter sizing for bus_arbiter2.
package bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TURN} arb_state_t;

    localparam logic SEL_I0 = 1'b1;
    localparam logic SEL_I1 = 1'b0;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// arb_hold_counter: up-counter with synchronous clear that saturates at LIMIT.
module arb_hold_counter
    import bus_arb_pkg::*;
#(
    parameter int LIMIT = 8,
    parameter int W = cnt_width(LIMIT)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && cnt != W'(LIMIT))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/bus_arbiter2.sv
// bus_arbiter2: two-source arbiter with hold limit and dead cycles ahead of a tristate 2:1 mux.
// Define BUS_ARB_FIXED_PRIO_EN for fixed source-0 priority (no round-robin, only GRANT1 is preemptable).
module bus_arbiter2
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic bus_en
);

    localparam int LIMIT = (MAX_HOLD > TURN_CYCLES) ? MAX_HOLD : TURN_CYCLES;
    localparam int CW = cnt_width(LIMIT);

    arb_state_t state, next, pick;
    logic [CW-1:0] cnt;
    logic sel_q, hold_end, turn_end, pre0, pre1;

    // One counter serves both the hold time and the turnaround; it restarts on every state change.
    arb_hold_counter #(.LIMIT(LIMIT), .W(CW)) u_cnt (
        .clk(clk),
        .rst_n(rst_n),
        .clear(next != state),
        .enable(state != IDLE),
        .cnt(cnt)
    );

    assign hold_end = cnt == CW'(MAX_HOLD - 1);
    assign turn_end = cnt == CW'(TURN_CYCLES - 1);

`ifdef BUS_ARB_FIXED_PRIO_EN
    assign pick = req0 ? GRANT0 : req1 ? GRANT1 : IDLE;
    assign pre0 = 1'b0;
    assign pre1 = hold_end && req0;
`else
    logic last;
    assign pick = (req0 && req1) ? (last ? GRANT0 : GRANT1) : req0 ? GRANT0 : req1 ? GRANT1 : IDLE;
    assign pre0 = hold_end && req1;
    assign pre1 = hold_end && req0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= SEL_I0;
`ifndef BUS_ARB_FIXED_PRIO_EN
            last  <= 1'b1;
`endif
        end else begin
            state <= next;
            sel_q <= (next == GRANT0) ? SEL_I0 : (next == GRANT1) ? SEL_I1 : sel_q;
`ifndef BUS_ARB_FIXED_PRIO_EN
            last  <= (state == GRANT0 && next != GRANT0) ? 1'b0 :
                     (state == GRANT1 && next != GRANT1) ? 1'b1 : last;
`endif
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = pick;
            GRANT0:  next = (!req0 || pre0) ? TURN : GRANT0;
            GRANT1:  next = (!req1 || pre1) ? TURN : GRANT1;
            default: next = turn_end ? pick : TURN;
        endcase
    end

    always_comb begin
        gnt0   = state == GRANT0;
        gnt1   = state == GRANT1;
        bus_en = gnt0 | gnt1;
        sel    = sel_q;
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// tb_bus_arbiter2: directed scoreboard bench for bus_arbiter2 (MAX_HOLD=8, TURN_CYCLES=1).
module tb_bus_arbiter2;

    typedef struct {
        logic [3:0] exp;
        string      tag;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0;
    logic req1 = 1'b0;
    logic gnt0, gnt1, sel, bus_en;
    int checks = 0;
    int errors = 0;
    sb_t sb[$];

    bus_arbiter2 #(.MAX_HOLD(8), .TURN_CYCLES(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req0(req0),
        .req1(req1),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .sel(sel),
        .bus_en(bus_en)
    );

    always #5 clk = ~clk;

    // exp packs {gnt0, gnt1, sel, bus_en} expected after the coming edge.
    task automatic step(input logic r0, input logic r1, input logic rn, input logic [3:0] exp, input string tag);
        sb_t e;
        logic [3:0] obs;
        req0 = r0;
        req1 = r1;
        rst_n = rn;
        sb.push_back('{exp, tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        obs = {gnt0, gnt1, sel, bus_en};
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
        end
        checks++;
        assert (!(gnt0 && gnt1) && bus_en === (gnt0 | gnt1)) else begin
            errors++;
            $error("FAIL %s_invariant observed=%b expected=no_overlap", e.tag, obs);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1, 1, 0, 4'b0010, "reset");
`ifdef BUS_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 50; i++) step(1, 1, 1, 4'b1011, "fixed_prio_gnt0");
`else
        // Both held: 8 cycles gnt0, 1 dead, 8 cycles gnt1, 1 dead, repeat.
        for (int i = 0; i < 36; i++) begin
            int p;
            p = i % 18;
            step(1, 1, 1, (p < 8) ? 4'b1011 : (p == 8) ? 4'b0010 : (p < 17) ? 4'b0101 : 4'b0000,
                 (i == 0) ? "release_gnt0" : "preempt");
        end
        step(0, 0, 1, 4'b0000, "turn_to_idle");
        for (int i = 0; i < 20; i++) step(0, 1, 1, 4'b0101, "single_gnt1");
        step(0, 0, 1, 4'b0000, "single_turn");
        step(0, 0, 1, 4'b0000, "single_idle");
        step(1, 0, 1, 4'b1011, "solo_gnt0");
        step(0, 0, 1, 4'b0010, "solo_turn");
        step(0, 0, 1, 4'b0010, "solo_idle");
        step(1, 1, 1, 4'b0101, "tie_rr_gnt1");
        for (int i = 0; i < 4; i++) step(1, 1, 1, 4'b0101, "hold_gnt1");
        step(1, 1, 0, 4'b0010, "reset_mid_grant");
        step(1, 1, 1, 4'b1011, "post_reset_gnt0");
        step(0, 0, 1, 4'b0010, "drop_turn");
        step(0, 0, 1, 4'b0010, "drop_idle");
        step(0, 1, 1, 4'b0101, "pulse_gnt1");
        step(0, 0, 1, 4'b0000, "pulse_turn");
        step(0, 0, 1, 4'b0000, "pulse_idle");
        step(1, 0, 1, 4'b1011, "handoff_gnt0");
        step(0, 1, 1, 4'b0010, "handoff_turn");
        step(0, 1, 1, 4'b0101, "handoff_gnt1");
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
